vram_fill_engine: RTL and testbench

//  68k-mapped rectangle-fill engine writing 12-bit RGB into the 320-wide pixel VRAM.
//  - CPU programs origin, size and colour, then starts the fill.
//  - Engine streams one pixel write per free cycle into the VRAM write port.
//  - Sits upstream of VRAM port A, beside the CPU's direct VRAM path; the CPU path always wins.

---
 rtl/vram_fill_engine_if.sv | 19 +
 rtl/vram_fill_engine.sv | 135 +++++++++++++
 tb/tb_vram_fill_engine.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/vram_fill_engine_if.sv
// vram_fill_engine_if: 68k register-window bus between the CPU and the fill engine
interface vram_fill_engine_if;
  logic        cs_n;
  logic        cpu_rw;
  logic        cpu_uds_n;
  logic        cpu_lds_n;
  logic [3:1]  cpu_a;
  logic [15:0] cpu_dout;
  logic [15:0] reg_do;
  logic        dtack_n;
  modport master (
    output cs_n, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_a, cpu_dout,
    input  reg_do, dtack_n
  );
  modport slave (
    input  cs_n, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_a, cpu_dout,
    output reg_do, dtack_n
  );
endinterface

// File: rtl/vram_fill_engine.sv
// vram_fill_engine: 68k-programmed rectangle fill into 320-wide 12-bit VRAM; define VRAM_FILL_IRQ_EN for a done interrupt
module vram_fill_engine #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int ADDR_W   = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  vram_fill_engine_if.slave     bus,
  input  logic                  cpu_vram_wr,
  output logic                  vram_we,
  output logic [ADDR_W-1:0]     vram_addr,
  output logic [11:0]           vram_data,
  output logic                  busy,
  output logic                  irq
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_e;
  state_e            state_q;
  logic              dtack_n_q, done_q;
  logic [15:0]       reg_do_q, reg_do_d, wm;
  logic [8:0]        x0_q, w_q;
  logic [7:0]        y0_q, h_q;
  logic [11:0]       color_q, color_sh_q;
  logic [9:0]        ew_q, eh_q, col_q, row_q;
  logic [9:0]        x_room, y_room, ew_d, eh_d;
  logic [ADDR_W-1:0] row_base_q, addr_q, base_d, next_row_d;
  logic              cs_fall, reg_wr, start, clr_done, unused;
  assign unused   = ^bus.cpu_dout[15:12];
  assign wm       = {{8{!bus.cpu_uds_n}}, {8{!bus.cpu_lds_n}}};
  assign cs_fall  = !bus.cs_n && dtack_n_q;
  assign reg_wr   = cs_fall && !bus.cpu_rw;
  assign start    = reg_wr && bus.cpu_a == 3'd5 && wm[0] && bus.cpu_dout[0];
  assign clr_done = reg_wr && bus.cpu_a == 3'd5 && wm[1] && bus.cpu_dout[1];
  // Clipping is done in 10 bits so SCREEN_W/H - origin never goes negative.
  assign x_room = ({1'b0, x0_q} >= 10'(SCREEN_W)) ? '0 : 10'(SCREEN_W) - {1'b0, x0_q};
  assign y_room = ({2'b0, y0_q} >= 10'(SCREEN_H)) ? '0 : 10'(SCREEN_H) - {2'b0, y0_q};
  assign ew_d   = ({1'b0, w_q} < x_room) ? {1'b0, w_q} : x_room;
  assign eh_d   = ({2'b0, h_q} < y_room) ? {2'b0, h_q} : y_room;
  // Y0*320 as (Y0<<8)+(Y0<<6) keeps the row base a pair of adds.
  assign base_d     = ADDR_W'({y0_q, 8'b0}) + ADDR_W'({y0_q, 6'b0}) + ADDR_W'(x0_q);
  assign next_row_d = row_base_q + ADDR_W'(SCREEN_W);
  assign vram_we    = state_q == S_FILL && !cpu_vram_wr;
  assign vram_addr  = addr_q;
  assign vram_data  = color_sh_q;
  assign busy       = state_q != S_IDLE;
  assign bus.reg_do  = reg_do_q;
  assign bus.dtack_n = dtack_n_q;
`ifdef VRAM_FILL_IRQ_EN
  assign irq = done_q;
`else
  assign irq = 1'b0;
`endif
  // Register read mux; CTRL and the spare slot read back as zero.
  always_comb begin
    reg_do_d = '0;
    case (bus.cpu_a)
      3'd0:    reg_do_d = {7'b0, x0_q};
      3'd1:    reg_do_d = {8'b0, y0_q};
      3'd2:    reg_do_d = {7'b0, w_q};
      3'd3:    reg_do_d = {8'b0, h_q};
      3'd4:    reg_do_d = {4'b0, color_q};
      3'd6:    reg_do_d = {14'b0, done_q, busy};
      default: reg_do_d = '0;
    endcase
  end
  // Bus handshake: dtack follows cs_n one cycle late, read data captured alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      dtack_n_q <= 1'b1;
      reg_do_q  <= '0;
    end else begin
      dtack_n_q <= bus.cs_n;
      reg_do_q  <= (!bus.cs_n && bus.cpu_rw) ? reg_do_d : '0;
    end
  end
  // Programming registers, byte-lane masked, written once per bus cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
    end else if (reg_wr) begin
      if (bus.cpu_a == 3'd0) x0_q <= (x0_q & ~wm[8:0]) | (bus.cpu_dout[8:0] & wm[8:0]);
      if (bus.cpu_a == 3'd1) y0_q <= (y0_q & ~wm[7:0]) | (bus.cpu_dout[7:0] & wm[7:0]);
      if (bus.cpu_a == 3'd2) w_q <= (w_q & ~wm[8:0]) | (bus.cpu_dout[8:0] & wm[8:0]);
      if (bus.cpu_a == 3'd3) h_q <= (h_q & ~wm[7:0]) | (bus.cpu_dout[7:0] & wm[7:0]);
      if (bus.cpu_a == 3'd4) color_q <= (color_q & ~wm[11:0]) | (bus.cpu_dout[11:0] & wm[11:0]);
    end
  end
  // Fill sequencer: snapshot the programmed rectangle, walk it row by row, yield to CPU writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      ew_q       <= '0;
      eh_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      color_sh_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_q <= S_SETUP;
        S_SETUP: begin
          ew_q       <= ew_d;
          eh_q       <= eh_d;
          color_sh_q <= color_q;
          row_base_q <= base_d;
          addr_q     <= base_d;
          col_q      <= '0;
          row_q      <= '0;
          state_q    <= (ew_d == '0 || eh_d == '0) ? S_DONE : S_FILL;
        end
        S_FILL: if (!cpu_vram_wr) begin
          if (col_q == ew_q - 10'd1) begin
            col_q      <= '0;
            row_q      <= row_q + 10'd1;
            row_base_q <= next_row_d;
            addr_q     <= next_row_d;
            if (row_q == eh_q - 10'd1) state_q <= S_DONE;
          end else begin
            col_q  <= col_q + 10'd1;
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      done_q <= (state_q == S_DONE) ? 1'b1 : clr_done ? 1'b0 : done_q;
    end
  end
endmodule

// File: tb/tb_vram_fill_engine.sv
// tb_vram_fill_engine: scoreboard bench for the rectangle-fill engine
module tb_vram_fill_engine;
`ifdef VRAM_FILL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  logic        clk = 0, reset = 1, cpu_vram_wr = 0;
  logic        vram_we, busy, irq;
  logic [16:0] vram_addr;
  logic [11:0] vram_data;
  logic [28:0] exp_q[$];
  logic [15:0] rd;
  int          n_cmp = 0, n_bad = 0, nwr = 0;
  vram_fill_engine_if bus();
  vram_fill_engine dut (
    .clk(clk), .reset(reset), .bus(bus), .cpu_vram_wr(cpu_vram_wr),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
    .busy(busy), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Scoreboard: every engine write is popped and compared against the model.
  always @(negedge clk) if (vram_we === 1'b1) begin
    logic [28:0] e;
    nwr++;
    if (exp_q.size() == 0) chk("spurious_we", 32'(vram_addr), 32'h1ffff);
    else begin
      e = exp_q.pop_front();
      chk("vram_addr", 32'(vram_addr), 32'(e[28:12]));
      chk("vram_data", 32'(vram_data), 32'(e[11:0]));
    end
  end
  task automatic push_rect(input int x, input int y, input int w, input int h, input logic [11:0] c);
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++) exp_q.push_back({17'((y + r) * 320 + x + k), c});
  endtask
  task automatic bus_wr(input logic [2:0] idx, input logic [15:0] d, input logic [1:0] strb = 2'b11);
    @(posedge clk); #1;
    bus.cs_n = 0; bus.cpu_rw = 0; bus.cpu_a = idx; bus.cpu_dout = d;
    bus.cpu_uds_n = !strb[1]; bus.cpu_lds_n = !strb[0];
    @(posedge clk); #1;
    bus.cs_n = 1; bus.cpu_rw = 1; bus.cpu_uds_n = 1; bus.cpu_lds_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic bus_rd(input logic [2:0] idx, output logic [15:0] d);
    @(posedge clk); #1;
    bus.cs_n = 0; bus.cpu_rw = 1; bus.cpu_a = idx; bus.cpu_uds_n = 0; bus.cpu_lds_n = 0;
    @(posedge clk); #1;
    chk("dtack_low", 32'(bus.dtack_n), 0);
    d = bus.reg_do;
    bus.cs_n = 1; bus.cpu_uds_n = 1; bus.cpu_lds_n = 1;
    @(posedge clk); #1;
    chk("dtack_high", 32'(bus.dtack_n), 1);
  endtask
  task automatic prog(input logic [15:0] x, input logic [15:0] y, input logic [15:0] w, input logic [15:0] h, input logic [15:0] c);
    bus_wr(3'd0, x); bus_wr(3'd1, y); bus_wr(3'd2, w); bus_wr(3'd3, h); bus_wr(3'd4, c);
  endtask
  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 2000 && busy; k++) begin @(posedge clk); #1; end
    if (busy) chk(tag, 32'(busy), 0);
  endtask
  task automatic wait_nwr(input int n, input string tag);
    int k;
    for (k = 0; k < 2000 && nwr < n; k++) @(posedge clk);
    if (nwr < n) chk(tag, 32'(nwr), 32'(n));
  endtask
  initial begin
    bus.cs_n = 1; bus.cpu_rw = 1; bus.cpu_uds_n = 1; bus.cpu_lds_n = 1; bus.cpu_a = 0; bus.cpu_dout = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_we", 32'(vram_we), 0);
    chk("rst_addr", 32'(vram_addr), 0);
    chk("rst_data", 32'(vram_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_dtack", 32'(bus.dtack_n), 1);
    chk("rst_regdo", 32'(bus.reg_do), 0);
    // byte lanes and register readback
    bus_wr(3'd0, 16'h0155); bus_rd(3'd0, rd); chk("x0_full", 32'(rd), 32'h155);
    bus_wr(3'd0, 16'h0000, 2'b01); bus_rd(3'd0, rd); chk("x0_lds_only", 32'(rd), 32'h100);
    bus_wr(3'd7, 16'hffff); bus_rd(3'd7, rd); chk("idx7", 32'(rd), 0);
    // test 1: basic 4x2
    prog(10, 2, 4, 2, 16'h0f00);
    push_rect(10, 2, 4, 2, 12'hf00);
    nwr = 0;
    bus_wr(3'd5, 16'h0001);
    wait_idle("t1_timeout");
    chk("t1_nwr", 32'(nwr), 8);
    chk("t1_left", 32'(exp_q.size()), 0);
    bus_rd(3'd6, rd); chk("t1_status", 32'(rd), 2);
    chk("t1_irq", 32'(irq), 32'(IRQ_ON));
    bus_wr(3'd5, 16'h0002); bus_rd(3'd6, rd); chk("clr_status", 32'(rd), 0);
    chk("clr_irq", 32'(irq), 0);
    // test 2: clipped corner
    prog(318, 239, 5, 3, 16'h00a5);
    push_rect(318, 239, 2, 1, 12'h0a5);
    nwr = 0;
    bus_wr(3'd5, 16'h0001);
    wait_idle("t2_timeout");
    chk("t2_nwr", 32'(nwr), 2);
    chk("t2_left", 32'(exp_q.size()), 0);
    bus_wr(3'd5, 16'h0002);
    // test 3: zero width, done in 3 cycles
    bus_wr(3'd2, 16'h0000);
    nwr = 0;
    @(posedge clk); #1;
    bus.cs_n = 0; bus.cpu_rw = 0; bus.cpu_a = 3'd5; bus.cpu_dout = 16'h0001; bus.cpu_uds_n = 0; bus.cpu_lds_n = 0;
    @(posedge clk); #1;
    bus.cs_n = 1; bus.cpu_rw = 1; bus.cpu_uds_n = 1; bus.cpu_lds_n = 1;
    chk("t3_busy_setup", 32'(busy), 1);
    @(posedge clk); #1;
    chk("t3_busy_done", 32'(busy), 1);
    chk("t3_irq_early", 32'(irq), 0);
    @(posedge clk); #1;
    chk("t3_busy_end", 32'(busy), 0);
    chk("t3_irq", 32'(irq), 32'(IRQ_ON));
    bus_rd(3'd6, rd); chk("t3_status", 32'(rd), 2);
    chk("t3_nwr", 32'(nwr), 0);
    bus_wr(3'd5, 16'h0002);
    // test 4: CPU stall after pixel 5
    prog(10, 2, 4, 2, 16'h0f00);
    push_rect(10, 2, 4, 2, 12'hf00);
    nwr = 0;
    bus_wr(3'd5, 16'h0001);
    wait_nwr(5, "t4_wait5");
    #1 cpu_vram_wr = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_stall_hold", 32'(nwr), 5);
    cpu_vram_wr = 0;
    wait_idle("t4_timeout");
    chk("t4_nwr", 32'(nwr), 8);
    chk("t4_left", 32'(exp_q.size()), 0);
    bus_wr(3'd5, 16'h0002);
    // test 5: restart and colour change mid-fill are ignored
    prog(0, 0, 16, 2, 16'h0123);
    push_rect(0, 0, 16, 2, 12'h123);
    nwr = 0;
    bus_wr(3'd5, 16'h0001);
    bus_wr(3'd4, 16'h0abc);
    bus_wr(3'd5, 16'h0001);
    chk("t5_busy_mid", 32'(busy), 1);
    wait_idle("t5_timeout");
    repeat (5) @(posedge clk);
    #1;
    chk("t5_nwr", 32'(nwr), 32);
    chk("t5_left", 32'(exp_q.size()), 0);
    chk("t5_busy_after", 32'(busy), 0);
    bus_wr(3'd5, 16'h0002);
    // test 6: reset after 3 pixels of 16x16
    prog(0, 0, 16, 16, 16'h0777);
    push_rect(0, 0, 3, 1, 12'h777);
    nwr = 0;
    bus_wr(3'd5, 16'h0001);
    wait_nwr(2, "t6_wait2");
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_nwr", 32'(nwr), 3);
    chk("t6_left", 32'(exp_q.size()), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_irq", 32'(irq), 0);
    bus_rd(3'd6, rd); chk("t6_status", 32'(rd), 0);
    bus_rd(3'd0, rd); chk("t6_x0", 32'(rd), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
